pi_sample_sequencer: RTL and testbench

PI_SAMPLE_SEQUENCER -- requirements
Module: pi_sample_sequencer

---
 rtl/pi_sample_sequencer.sv | 138 +++++++++++++
 tb/tb_pi_sample_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pi_sample_sequencer.sv
// rtl/pi_sample_sequencer.sv - Monte-Carlo pi sample sequencer: clears a square pixel region, then plots accepted random samples
//
// Ports:
//   clk                 single clock, rising edge
//   reset               synchronous, active-low
//   start, stop         one-cycle command pulses (start wins over stop)
//   sample_tick         one-cycle pulse, rand_x/rand_y hold a new sample
//   rand_x, rand_y      9-bit random coordinates
//   is_inside           combinational circle test of the current wr_x/wr_y
//   wr_x, wr_y, wr_data, wr_en   registered pixel memory write port
//   busy, done          status (busy in CLEAR/RUN, done in DONE)
//   hits, total         inside-circle count and accepted-sample count
module pi_sample_sequencer #(
    parameter int SIDE         = 480,
    parameter int SAMPLE_LIMIT = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        sample_tick,
    input  logic [8:0]  rand_x,
    input  logic [8:0]  rand_y,
    input  logic        is_inside,
    output logic [9:0]  wr_x,
    output logic [9:0]  wr_y,
    output logic        wr_data,
    output logic        wr_en,
    output logic        busy,
    output logic        done,
    output logic [15:0] hits,
    output logic [15:0] total
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [9:0]  SIDE_W  = 10'(SIDE);
    localparam logic [9:0]  SIDE_M1 = 10'(SIDE - 1);
    localparam logic [15:0] LIMIT   = 16'(SAMPLE_LIMIT);

    logic [1:0]  state, state_nx;
    logic [9:0]  x_nx, y_nx;
    logic        data_nx, en_nx;
    logic [15:0] hits_nx, total_nx;
    logic        tick_ok;
    logic        last_sample;

    assign tick_ok = sample_tick && ({1'b0, rand_x} < SIDE_W) && ({1'b0, rand_y} < SIDE_W);

    // In RUN, wr_en only ever marks a sample write, so it doubles as the
    // "count this cycle" flag; is_inside refers to the address on the bus now.
    assign last_sample = wr_en && (total + 16'd1 == LIMIT);

    always_comb begin
        state_nx = state;
        x_nx     = wr_x;
        y_nx     = wr_y;
        data_nx  = wr_data;
        en_nx    = 1'b0;
        hits_nx  = hits;
        total_nx = total;
        if (start) begin
            state_nx = CLEAR;
            x_nx     = 10'd0;
            y_nx     = 10'd0;
            data_nx  = 1'b0;
            en_nx    = 1'b1;
            hits_nx  = 16'd0;
            total_nx = 16'd0;
        end else begin
            case (state)
                CLEAR: begin
                    if (stop) begin
                        state_nx = IDLE;
                    end else if (wr_x == SIDE_M1 && wr_y == SIDE_M1) begin
                        // last pixel is being written now; address holds into RUN
                        state_nx = RUN;
                    end else begin
                        en_nx = 1'b1;
                        if (wr_x == SIDE_M1) begin
                            x_nx = 10'd0;
                            y_nx = wr_y + 10'd1;
                        end else begin
                            x_nx = wr_x + 10'd1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_nx = IDLE;
                    end else begin
                        if (wr_en) begin
                            total_nx = total + 16'd1;
                            hits_nx  = hits + {15'd0, is_inside};
                        end
                        if (last_sample) begin
                            state_nx = DONE;
                        end else if (tick_ok) begin
                            en_nx   = 1'b1;
                            x_nx    = {1'b0, rand_x};
                            y_nx    = {1'b0, rand_y};
                            data_nx = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            wr_x    <= 10'd0;
            wr_y    <= 10'd0;
            wr_data <= 1'b0;
            wr_en   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hits    <= 16'd0;
            total   <= 16'd0;
        end else begin
            state   <= state_nx;
            wr_x    <= x_nx;
            wr_y    <= y_nx;
            wr_data <= data_nx;
            wr_en   <= en_nx;
            busy    <= (state_nx == CLEAR) || (state_nx == RUN);
            done    <= (state_nx == DONE);
            hits    <= hits_nx;
            total   <= total_nx;
        end
    end

endmodule

// File: tb/tb_pi_sample_sequencer.sv
// tb/tb_pi_sample_sequencer.sv - directed self-checking bench for pi_sample_sequencer (SIDE=4, SAMPLE_LIMIT=3)
module tb_pi_sample_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, stop, sample_tick, is_inside;
    logic [8:0]  rand_x, rand_y;
    logic [9:0]  wr_x, wr_y;
    logic        wr_data, wr_en, busy, done;
    logic [15:0] hits, total;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pi_sample_sequencer #(.SIDE(4), .SAMPLE_LIMIT(3)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .sample_tick(sample_tick), .rand_x(rand_x), .rand_y(rand_y),
        .is_inside(is_inside), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .wr_en(wr_en), .busy(busy), .done(done), .hits(hits), .total(total)
    );

    // circle of radius^2 = 8 centred at the origin
    always_comb is_inside = (int'(wr_x) * int'(wr_x) + int'(wr_y) * int'(wr_y)) <= 8;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic tick(input logic [8:0] x, input logic [8:0] y);
        sample_tick = 1'b1; rand_x = x; rand_y = y;
        cyc();
        sample_tick = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; sample_tick = 1'b0;
        rand_x = 9'd0; rand_y = 9'd0;
        cyc(); cyc();
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_total", total, 0);
        check("rst_wr_x", wr_x, 0);
        reset = 1'b1;
        cyc();
        check("idle_wr_en", wr_en, 0);

        // clear sweep
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            check("clr_en", wr_en, 1);
            check("clr_x", wr_x, i % 4);
            check("clr_y", wr_y, i / 4);
            check("clr_data", wr_data, 0);
            check("clr_busy", busy, 1);
            cyc();
        end
        check("run_en", wr_en, 0);
        check("run_busy", busy, 1);

        // three samples to the limit
        tick(9'd1, 9'd2);
        check("s1_en", wr_en, 1);
        check("s1_x", wr_x, 1);
        check("s1_y", wr_y, 2);
        check("s1_data", wr_data, 1);
        cyc();
        check("s1_total", total, 1);
        check("s1_hits", hits, 1);
        tick(9'd3, 9'd0);
        check("s2_en", wr_en, 1);
        cyc();
        check("s2_total", total, 2);
        check("s2_hits", hits, 1);
        tick(9'd2, 9'd2);
        check("s3_en", wr_en, 1);
        cyc();
        check("s3_total", total, 3);
        check("s3_hits", hits, 2);
        check("s3_done", done, 1);
        check("s3_busy", busy, 0);
        tick(9'd0, 9'd0);
        check("s4_en", wr_en, 0);
        cyc();
        check("s4_total", total, 3);

        // out-of-range samples
        pulse_start();
        repeat (16) cyc();
        tick(9'd4, 9'd1);
        check("oor1_en", wr_en, 0);
        tick(9'd1, 9'd9);
        check("oor2_en", wr_en, 0);
        cyc();
        check("oor_total", total, 0);
        check("oor_busy", busy, 1);

        // back-to-back ticks
        sample_tick = 1'b1; rand_x = 9'd0; rand_y = 9'd1;
        cyc();
        check("bb1_en", wr_en, 1);
        check("bb1_y", wr_y, 1);
        rand_x = 9'd2; rand_y = 9'd3;
        cyc();
        check("bb2_en", wr_en, 1);
        check("bb2_x", wr_x, 2);
        check("bb2_y", wr_y, 3);
        rand_x = 9'd3; rand_y = 9'd3;
        cyc();
        check("bb3_en", wr_en, 1);
        check("bb3_x", wr_x, 3);
        sample_tick = 1'b0;
        cyc();
        check("bb_en_off", wr_en, 0);
        check("bb_total", total, 3);
        check("bb_hits", hits, 1);
        check("bb_done", done, 1);

        // stop during clear at write 5
        pulse_start();
        repeat (4) cyc();
        check("stp_w5_x", wr_x, 0);
        check("stp_w5_y", wr_y, 1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("stp_en", wr_en, 0);
        check("stp_busy", busy, 0);
        check("stp_done", done, 0);
        check("stp_total", total, 0);
        check("stp_hold_y", wr_y, 1);
        cyc();
        check("stp_idle_en", wr_en, 0);
        pulse_start();
        check("rs_en", wr_en, 1);
        check("rs_x", wr_x, 0);
        check("rs_y", wr_y, 0);

        // mid-run reset, then start+stop together, tick during clear
        repeat (16) cyc();
        tick(9'd1, 9'd1);
        cyc();
        check("pre_rst_total", total, 1);
        check("pre_rst_hits", hits, 1);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        check("mr_en", wr_en, 0);
        check("mr_data", wr_data, 0);
        check("mr_x", wr_x, 0);
        check("mr_y", wr_y, 0);
        check("mr_busy", busy, 0);
        check("mr_total", total, 0);
        check("mr_hits", hits, 0);
        cyc();
        check("mr_idle_busy", busy, 0);
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        check("ss_busy", busy, 1);
        check("ss_en", wr_en, 1);
        tick(9'd3, 9'd3);
        check("ctick_x", wr_x, 1);
        check("ctick_y", wr_y, 0);
        check("ctick_data", wr_data, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
